// File: rtl/controle_varredura_mux_pkg.sv
// Shared definitions for the Ping-Pong selector-scan datapath.
// Holds the selector range, the frame width and the scan FSM encoding.
package ping_pong_pkg;

  localparam logic [3:0] SEL_PRIMEIRO = 4'd1;
  localparam logic [3:0] SEL_ULTIMO   = 4'd15;
  localparam int         QUADRO_W     = 15;

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    VARRE   = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

endpackage

// File: rtl/controle_varredura_mux_divisor_passo.sv
// Dwell counter for the selector scan.
// Counts 0..DIVISOR-1 while enabled and wraps back to 0.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset
//   clear  - forces the count back to 0 (dominates enable)
//   enable - advance the count this clock
//   fim    - terminal count, high while the count equals DIVISOR-1
module divisor_passo #(
  parameter int DIVISOR = 4,
  parameter int CONT_W  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam logic [CONT_W-1:0] TERMINAL = CONT_W'(DIVISOR - 1);

  logic [CONT_W-1:0] r_contador;

  // The count wraps on its own at the terminal value so a running scan
  // needs no extra clear between selector positions.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_contador <= '0;
    end else if (enable) begin
      if (r_contador == TERMINAL) begin
        r_contador <= '0;
      end else begin
        r_contador <= r_contador + 1'b1;
      end
    end
  end

  assign fim = (r_contador == TERMINAL);

endmodule

// File: rtl/controle_varredura_mux.sv
// Scan controller for the 15-input selector mux of the Ping-Pong datapath.
// Steps seletor through 1..15, dwelling DIVISOR clocks on each position,
// samples saida_mux on the last dwell clock and delivers the 15 samples as
// a frame with a valid/accept handshake.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   habilita       - run (1) / stop and abort (0) scanning
//   saida_mux      - mux output for the current seletor
//   seletor        - registered select code, always 1..15
//   passo          - one-cycle pulse after each sample
//   quadro         - last completed frame, bit i sampled at seletor i+1
//   quadro_valido  - quadro holds a frame not yet accepted
//   quadro_aceito  - consumer accept, effective only while quadro_valido
//   ocupado        - FSM is not idle
module controle_varredura_mux
  import ping_pong_pkg::*;
#(
  parameter int DIVISOR = 4,
  parameter int CONT_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic                saida_mux,
  output logic [3:0]          seletor,
  output logic                passo,
  output logic [QUADRO_W-1:0] quadro,
  output logic                quadro_valido,
  input  logic                quadro_aceito,
  output logic                ocupado
);

  estado_t             r_estado;
  estado_t             w_proximo;
  logic [3:0]          r_seletor;
  logic [QUADRO_W-1:0] r_acumulador;
  logic [QUADRO_W-1:0] r_quadro;
  logic                r_valido;
  logic                r_passo;
  logic                w_varrendo;
  logic                w_fim;
  logic                w_amostra;
  logic                w_ultimo;
  logic [3:0]          w_indice;

  // Counting only happens during an enabled scan; dropping habilita
  // clears the dwell so a restart begins a full dwell period.
  assign w_varrendo = (r_estado == VARRE) && habilita;
  assign w_amostra  = w_varrendo && w_fim;
  assign w_ultimo   = (r_seletor == SEL_ULTIMO);
  assign w_indice   = r_seletor - SEL_PRIMEIRO;

  divisor_passo #(
    .DIVISOR (DIVISOR),
    .CONT_W  (CONT_W)
  ) u_divisor (
    .clock  (clock),
    .reset  (reset),
    .clear  (!w_varrendo),
    .enable (w_varrendo),
    .fim    (w_fim)
  );

  // Next-state logic: an abort wins over a sample on the same edge, and
  // ENTREGA waits for accept regardless of habilita.
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      PARADO: begin
        if (habilita) w_proximo = VARRE;
      end
      VARRE: begin
        if (!habilita) begin
          w_proximo = PARADO;
        end else if (w_fim && w_ultimo) begin
          w_proximo = ENTREGA;
        end
      end
      ENTREGA: begin
        if (quadro_aceito) w_proximo = habilita ? VARRE : PARADO;
      end
      default: w_proximo = PARADO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= PARADO;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Selector, sample accumulator and frame handshake registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seletor    <= SEL_PRIMEIRO;
      r_acumulador <= '0;
      r_quadro     <= '0;
      r_valido     <= 1'b0;
      r_passo      <= 1'b0;
    end else begin
      r_passo <= w_amostra;
      if (!w_varrendo) begin
        r_seletor    <= SEL_PRIMEIRO;
        r_acumulador <= '0;
      end else if (w_amostra) begin
        if (w_ultimo) begin
          r_seletor    <= SEL_PRIMEIRO;
          r_acumulador <= '0;
          r_quadro     <= {saida_mux, r_acumulador[QUADRO_W-2:0]};
          r_valido     <= 1'b1;
        end else begin
          r_seletor              <= r_seletor + 1'b1;
          r_acumulador[w_indice] <= saida_mux;
        end
      end
      if ((r_estado == ENTREGA) && r_valido && quadro_aceito) begin
        r_valido <= 1'b0;
      end
    end
  end

  assign seletor       = r_seletor;
  assign passo         = r_passo;
  assign quadro        = r_quadro;
  assign quadro_valido = r_valido;
  assign ocupado       = (r_estado != PARADO);

endmodule

// File: tb/tb_controle_varredura_mux.sv
// Directed self-checking bench for controle_varredura_mux with DIVISOR = 4.
module tb_controle_varredura_mux;

  logic        clock = 1'b0;
  logic        reset;
  logic        habilita;
  logic        saida_mux;
  logic [3:0]  seletor;
  logic        passo;
  logic [14:0] quadro;
  logic        quadro_valido;
  logic        quadro_aceito;
  logic        ocupado;

  int nAsserts  = 0;
  int nFailures = 0;
  int muxMode   = 0;

  controle_varredura_mux #(
    .DIVISOR (4),
    .CONT_W  (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .saida_mux     (saida_mux),
    .seletor       (seletor),
    .passo         (passo),
    .quadro        (quadro),
    .quadro_valido (quadro_valido),
    .quadro_aceito (quadro_aceito),
    .ocupado       (ocupado)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Behavioural mux model: output pattern chosen by muxMode.
  always_comb begin
    case (muxMode)
      0:       saida_mux = seletor[0];
      1:       saida_mux = 1'b1;
      default: saida_mux = ~seletor[0];
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    if (observed !== expected) begin
      nFailures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hab, input logic ace);
    reset         = rst;
    habilita      = hab;
    quadro_aceito = ace;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs until quadro_valido rises, recording cycle count, pulse count and
  // pulses not spaced exactly 4 clocks apart.
  task automatic runFrame(output int cycles, output int pulses, output int gaps);
    int last;
    cycles = 0;
    pulses = 0;
    gaps   = 0;
    last   = 0;
    while (!quadro_valido && cycles < 200) begin
      tick();
      cycles++;
      if (passo) begin
        pulses++;
        if (cycles - last != 4) gaps++;
        last = cycles;
      end
    end
  endtask

  task automatic waitSeletor(input logic [3:0] alvo, input string tag);
    int n = 0;
    while (seletor != alvo && n < 200) begin
      tick();
      n++;
    end
    checkOutput(tag, {28'd0, seletor}, {28'd0, alvo});
  endtask

  task automatic waitPasso(output int cycles);
    cycles = 0;
    while (cycles < 50) begin
      tick();
      cycles++;
      if (passo) break;
    end
  endtask

  initial begin
    int cyc, pul, gap, extra, bad;

    // Reset held two cycles with habilita high.
    applyStimulus(1'b1, 1'b1, 1'b0);
    muxMode = 0;
    tick();
    tick();
    checkOutput("rst_seletor", {28'd0, seletor}, 32'd1);
    checkOutput("rst_quadro", {17'd0, quadro}, 32'd0);
    checkOutput("rst_valido", {31'd0, quadro_valido}, 32'd0);
    checkOutput("rst_passo", {31'd0, passo}, 32'd0);
    checkOutput("rst_ocupado", {31'd0, ocupado}, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("ocupado_after_rst", {31'd0, ocupado}, 32'd1);

    // Full frame with saida_mux = seletor[0].
    runFrame(cyc, pul, gap);
    checkOutput("frame1_cycles", cyc, 32'd60);
    checkOutput("frame1_pulses", pul, 32'd15);
    checkOutput("frame1_gaps", gap, 32'd0);
    checkOutput("frame1_quadro", {17'd0, quadro}, 32'h5555);

    // Backpressure: hold accept low for 10 cycles.
    extra = 0;
    bad   = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (passo) extra++;
      if (seletor != 4'd1 || quadro != 15'h5555 || !quadro_valido) bad++;
    end
    checkOutput("hold_passo", extra, 32'd0);
    checkOutput("hold_stable", bad, 32'd0);
    quadro_aceito = 1'b1;
    tick();
    quadro_aceito = 1'b0;
    checkOutput("accept_valido", {31'd0, quadro_valido}, 32'd0);
    checkOutput("accept_ocupado", {31'd0, ocupado}, 32'd1);
    waitPasso(cyc);
    checkOutput("restart_first_passo", cyc, 32'd4);
    checkOutput("restart_seletor", {28'd0, seletor}, 32'd2);

    // Abort at seletor 7.
    waitSeletor(4'd7, "wait_sel7");
    habilita = 1'b0;
    tick();
    checkOutput("abort_ocupado", {31'd0, ocupado}, 32'd0);
    checkOutput("abort_seletor", {28'd0, seletor}, 32'd1);
    checkOutput("abort_valido", {31'd0, quadro_valido}, 32'd0);
    checkOutput("abort_quadro", {17'd0, quadro}, 32'h5555);

    // Re-enable with saida_mux = 1; no stale bits from the aborted frame.
    muxMode  = 1;
    habilita = 1'b1;
    tick();
    runFrame(cyc, pul, gap);
    checkOutput("frame2_cycles", cyc, 32'd60);
    checkOutput("frame2_quadro", {17'd0, quadro}, 32'h7FFF);

    // Accept with habilita low returns to PARADO.
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    quadro_aceito = 1'b0;
    checkOutput("accept_idle_valido", {31'd0, quadro_valido}, 32'd0);
    checkOutput("accept_idle_ocupado", {31'd0, ocupado}, 32'd0);

    // Spurious accept while idle.
    quadro_aceito = 1'b1;
    tick();
    quadro_aceito = 1'b0;
    checkOutput("spur_idle_ocupado", {31'd0, ocupado}, 32'd0);
    checkOutput("spur_idle_valido", {31'd0, quadro_valido}, 32'd0);
    checkOutput("spur_idle_quadro", {17'd0, quadro}, 32'h7FFF);

    // Spurious accept mid-scan must not disturb timing.
    muxMode  = 0;
    habilita = 1'b1;
    tick();
    tick();
    quadro_aceito = 1'b1;
    tick();
    quadro_aceito = 1'b0;
    waitPasso(cyc);
    checkOutput("spur_scan_first_passo", cyc + 2, 32'd4);
    checkOutput("spur_scan_valido", {31'd0, quadro_valido}, 32'd0);

    // Mid-scan reset at seletor 9.
    waitSeletor(4'd9, "wait_sel9");
    reset = 1'b1;
    tick();
    checkOutput("midrst_seletor", {28'd0, seletor}, 32'd1);
    checkOutput("midrst_quadro", {17'd0, quadro}, 32'd0);
    checkOutput("midrst_ocupado", {31'd0, ocupado}, 32'd0);
    checkOutput("midrst_passo", {31'd0, passo}, 32'd0);
    reset   = 1'b0;
    muxMode = 2;
    tick();
    runFrame(cyc, pul, gap);
    checkOutput("frame3_cycles", cyc, 32'd60);
    checkOutput("frame3_pulses", pul, 32'd15);
    checkOutput("frame3_quadro", {17'd0, quadro}, 32'h2AAA);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
    $finish;
  end

endmodule

// File: doc/controle_varredura_mux.md
Name: controle_varredura_mux

Overview:
Scan controller for the 15-input selector multiplexer of the Ping-Pong datapath.
- Drives the 4-bit `seletor` through positions 1..15, dwelling DIVISOR clocks on each position.
- On the last clock of each dwell it samples the mux output (`saida_mux`) and assembles the 15 samples into a frame word.
- It hands the frame to the consumer (game/display logic) with a valid/accept handshake.

Parameters:
- DIVISOR, 4, clocks spent on each selector position; legal range 2..255; the first DIVISOR-1 clocks are mux settling time.
- CONT_W, 8, width of the dwell counter; must satisfy 2**CONT_W >= DIVISOR.

Ports:
- clock  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  synchronous, active-high reset.
- habilita  input  1  1 = run scanning; 0 = stop/abort scanning.
- saida_mux  input  1  output of the 15-input mux (combinational function of `seletor`).
- seletor  output  4  select code to the mux; registered; only values 1..15 are ever driven.
- passo  output  1  one-cycle pulse, high in the cycle after each sample; coincides with the new `seletor` value.
- quadro  output  15  last completed frame; quadro[i] = sample taken while seletor = i+1.
- quadro_valido  output  1  `quadro` holds an unconsumed frame.
- quadro_aceito  input  1  consumer accept; only effective while quadro_valido = 1.
- ocupado  output  1  1 whenever the state is not PARADO.

Behaviour:
- Reset (synchronous, active-high, dominant over every other input):
  - seletor = 1; contador = 0; acumulador = 0; quadro = 0.
  - quadro_valido = 0; passo = 0; state = PARADO.
- States: PARADO, VARRE, ENTREGA.
- PARADO:
  - seletor held at 1; contador held at 0; passo = 0.
  - If habilita = 1, go to VARRE at the next edge.
- VARRE:
  - contador increments every clock.
  - In the cycle where contador == DIVISOR-1, the next edge does all of the following:
    - acumulador[seletor-1] <= saida_mux;
    - contador <= 0;
    - passo <= 1 for exactly one cycle.
  - If seletor < 15 at that edge: seletor <= seletor+1.
  - If seletor == 15 at that edge:
    - quadro <= acumulador with bit 14 replaced by the new sample;
    - quadro_valido <= 1; seletor <= 1; acumulador <= 0; go to ENTREGA.
  - habilita = 0 in any VARRE cycle: at the next edge go to PARADO, seletor = 1, contador = 0, and the partial acumulador is discarded (cleared). quadro and quadro_valido are untouched.
  - habilita = 0 takes priority over a sample falling on the same edge; that sample is not written.
- ENTREGA:
  - seletor held at 1; contador held at 0; scanning is paused; quadro is stable.
  - If quadro_aceito = 1: at the next edge quadro_valido <= 0, then go to VARRE if habilita = 1, else PARADO.
  - habilita = 0 while in ENTREGA does not drop the frame; the block still waits for accept.
- Latency:
  - Entering VARRE at edge E0, the k-th sample (k = 1..15) occurs at edge E0 + k*DIVISOR.
  - quadro_valido is high after edge E0 + 15*DIVISOR.
  - A new frame begins on the edge that consumes the accept.
- quadro_aceito while quadro_valido = 0 is ignored and has no effect on state.
- Exactly 15 passo pulses are produced per completed frame; no pulses occur in PARADO or ENTREGA.
- seletor never takes the value 0; the wrap is always 15 -> 1.
- All outputs are registered except ocupado, which is decoded directly from the state register.

Decomposition:
- Shared package `ping_pong_pkg` holds:
  - constants SEL_PRIMEIRO = 4'd1, SEL_ULTIMO = 4'd15, QUADRO_W = 15;
  - the state encoding: PARADO = 2'd0, VARRE = 2'd1, ENTREGA = 2'd2.
- One natural sub-module: `divisor_passo`, the dwell counter.
  - Inputs: clock, reset, clear, enable.
  - Output: a terminal-count flag `fim` asserted when contador == DIVISOR-1.
  - Parameterised by DIVISOR and CONT_W.
- The FSM, seletor register, acumulador and handshake live in the top module.

Test Plan:
1. Reset: assert reset 2 cycles with habilita = 1 -> seletor = 1, quadro = 0, quadro_valido = 0, passo = 0, ocupado = 0; ocupado = 1 one edge after reset releases.
2. Full frame: DIVISOR = 4, saida_mux = seletor[0], quadro_aceito = 0 -> quadro_valido rises 60 clocks after VARRE entry, quadro = 15'h5555, and passo pulses 15 times, 4 clocks apart.
3. Backpressure: hold quadro_aceito = 0 for 10 cycles after valid -> seletor stays 1, quadro stays 15'h5555, no passo; pulse accept for 1 cycle -> quadro_valido = 0 next edge and a new frame starts (first passo 4 clocks later).
4. Abort: drop habilita while seletor = 7 -> next edge PARADO, seletor = 1, ocupado = 0, quadro_valido stays 0; re-enable with saida_mux = 1 -> next frame = 15'h7FFF with no stale bits.
5. Mid-scan reset: assert reset while seletor = 9 in VARRE -> next edge all reset values; a following full frame with saida_mux = ~seletor[0] gives quadro = 15'h2AAA.
6. Spurious accept: pulse quadro_aceito in PARADO and mid-VARRE -> no state change, scanning timing unaffected, quadro_valido stays 0.
